reg_scoreboard: RTL and testbench

- Producer-side companion to the EX/MEM/WB data-forwarding logic.
- Tracks outstanding register writes from issue until writeback, one saturating counter per architectural register.
- Raises a decode-stage stall when a source operand's newest value has not been written back and cannot yet be forwarded.
- Sits between the ID stage, the issue point and the WB stage.

---
 rtl/reg_scoreboard_pkg.sv | 14 +
 rtl/reg_scoreboard_sb_counter.sv | 46 ++++
 rtl/reg_scoreboard.sv | 119 +++++++++++
 tb/tb_reg_scoreboard.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg
// Shared defaults for the register scoreboard and its per-register counters.
//   NREG_DEFAULT  : architectural register count (register 0 is hard-wired zero)
//   AW_DEFAULT    : register-address width, 2**AW_DEFAULT == NREG_DEFAULT
//   CNT_W_DEFAULT : width of each outstanding-write counter
//   REG_ZERO      : index of the hard-wired zero register, never tracked
package reg_scoreboard_pkg;

    localparam int NREG_DEFAULT  = 32;
    localparam int AW_DEFAULT    = 5;
    localparam int CNT_W_DEFAULT = 2;
    localparam int REG_ZERO      = 0;

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// sb_counter
// One saturating up/down counter of outstanding writes to a single register.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : an accepted issue targets this register
//   dec        : writeback targets this register (ignored while count is 0)
//   clr        : pipeline flush, wins over inc/dec
//   count      : current number of outstanding writes
//   nonzero    : count != 0
module sb_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         nonzero
);

    logic dec_eff;
    logic at_max;

    assign nonzero = (count != '0);
    // A writeback with nothing outstanding is an underflow; the top flags it,
    // the counter itself just stays at zero.
    assign dec_eff = dec && nonzero;
    assign at_max  = (count == {W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !dec_eff) begin
            // The top stalls issue at max, so saturation is only a safety net.
            if (!at_max) begin
                count <= count + W'(1);
            end
        end else if (dec_eff && !inc) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
// Tracks in-flight register writes from issue to writeback and stalls decode
// when a source operand's newest value is neither written back nor forwardable.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   rs_id, rt_id          : ID-stage source registers
//   use_rs, use_rt        : ID instruction actually reads rs_id / rt_id
//   issue_valid, issue_wr : ID instruction wants to issue / writes a register
//   issue_rd              : destination of the issuing instruction
//   wb_valid, wb_rd       : writeback this cycle and its destination
//   flush                 : synchronous clear of all outstanding writes
//   stall                 : hold ID/IF, issue not accepted
//   issue_ack             : issue accepted this cycle
//   busy_vec              : bit r set while register r has outstanding writes
//   sb_empty              : no outstanding writes anywhere
//   sb_err                : sticky, writeback seen to a register with count 0
//
// Handshake: issue_valid is the request, issue_ack = issue_valid && !stall is
// the grant. An issue takes effect only on a rising edge where issue_ack is 1;
// the requester keeps issue_valid and its fields stable while stalled.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NREG  = NREG_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT,
    parameter int AW    = AW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs_id,
    input  logic [AW-1:0]   rt_id,
    input  logic            use_rs,
    input  logic            use_rt,
    input  logic            issue_valid,
    input  logic            issue_wr,
    input  logic [AW-1:0]   issue_rd,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic            flush,
    output logic            stall,
    output logic            issue_ack,
    output logic [NREG-1:0] busy_vec,
    output logic            sb_empty,
    output logic            sb_err
);

    localparam logic [AW-1:0]    RZ      = AW'(REG_ZERO);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NREG-1:0][CNT_W-1:0] cnt;
    logic [CNT_W-1:0]           cnt_rs;
    logic [CNT_W-1:0]           cnt_rt;
    logic [CNT_W-1:0]           cnt_rd;
    logic [CNT_W-1:0]           cnt_wb;
    logic                       haz_a;
    logic                       haz_b;
    logic                       haz_ovf;
    logic                       underflow;

    assign cnt[0]      = '0;
    assign busy_vec[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        sb_counter #(.W(CNT_W)) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc     (issue_ack && issue_wr && (issue_rd == AW'(r))),
            .dec     (wb_valid && (wb_rd == AW'(r))),
            .clr     (flush),
            .count   (cnt[r]),
            .nonzero (busy_vec[r])
        );
    end

    assign cnt_rs = cnt[rs_id];
    assign cnt_rt = cnt[rt_id];
    assign cnt_rd = cnt[issue_rd];
    assign cnt_wb = cnt[wb_rd];

    always_comb begin
        haz_a     = 1'b0;
        haz_b     = 1'b0;
        haz_ovf   = 1'b0;
        stall     = 1'b0;
        issue_ack = 1'b0;
        // A source with exactly one outstanding write retiring in WB right now
        // is served by the WB bypass, so it does not stall.
        if (use_rs && rs_id != RZ && cnt_rs != '0 &&
            !(wb_valid && wb_rd == rs_id && cnt_rs == CNT_ONE)) begin
            haz_a = 1'b1;
        end
        if (use_rt && rt_id != RZ && cnt_rt != '0 &&
            !(wb_valid && wb_rd == rt_id && cnt_rt == CNT_ONE)) begin
            haz_b = 1'b1;
        end
        // A full counter can still take an issue if WB retires one in the same
        // cycle; the counter then holds its value.
        if (issue_wr && issue_rd != RZ && cnt_rd == CNT_MAX &&
            !(wb_valid && wb_rd == issue_rd)) begin
            haz_ovf = 1'b1;
        end
        stall     = issue_valid && (haz_a || haz_b || haz_ovf);
        issue_ack = issue_valid && !stall;
    end

    assign underflow = wb_valid && wb_rd != RZ && cnt_wb == '0;
    assign sb_empty  = ~|busy_vec;

    // Sticky until reset; flush deliberately leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_err <= 1'b0;
        end else if (underflow) begin
            sb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard
// Directed bench for reg_scoreboard: reset, load-use stall, multiple in-flight
// writes, counter saturation, register-0/underflow, flush and async reset.
module tb_reg_scoreboard;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs_id;
    logic [4:0]  rt_id;
    logic        use_rs;
    logic        use_rt;
    logic        issue_valid;
    logic        issue_wr;
    logic [4:0]  issue_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        stall;
    logic        issue_ack;
    logic [31:0] busy_vec;
    logic        sb_empty;
    logic        sb_err;

    int total = 0;
    int bad   = 0;

    reg_scoreboard dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs_id       (rs_id),
        .rt_id       (rt_id),
        .use_rs      (use_rs),
        .use_rt      (use_rt),
        .issue_valid (issue_valid),
        .issue_wr    (issue_wr),
        .issue_rd    (issue_rd),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .flush       (flush),
        .stall       (stall),
        .issue_ack   (issue_ack),
        .busy_vec    (busy_vec),
        .sb_empty    (sb_empty),
        .sb_err      (sb_err)
    );

    // clock: posedge at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rs_id       = 5'd0;
        rt_id       = 5'd0;
        use_rs      = 1'b0;
        use_rt      = 1'b0;
        issue_valid = 1'b0;
        issue_wr    = 1'b0;
        issue_rd    = 5'd0;
        wb_valid    = 1'b0;
        wb_rd       = 5'd0;
        flush       = 1'b0;
    endtask

    // advance one edge, then let registered outputs settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd);
        idle();
        issue_valid = 1'b1;
        issue_wr    = 1'b1;
        issue_rd    = rd;
    endtask

    task automatic wb(input logic [4:0] rd);
        idle();
        wb_valid = 1'b1;
        wb_rd    = rd;
    endtask

    initial begin
        // ---------------- reset with random inputs ----------------
        rst_n       = 1'b0;
        rs_id       = 5'($urandom_range(0, 31));
        rt_id       = 5'($urandom_range(0, 31));
        use_rs      = 1'($urandom_range(0, 1));
        use_rt      = 1'($urandom_range(0, 1));
        issue_valid = 1'($urandom_range(0, 1));
        issue_wr    = 1'($urandom_range(0, 1));
        issue_rd    = 5'($urandom_range(0, 31));
        wb_valid    = 1'($urandom_range(0, 1));
        wb_rd       = 5'($urandom_range(0, 31));
        flush       = 1'($urandom_range(0, 1));
        tick();
        tick();
        chk("rst_busy", busy_vec, 32'h0);
        chk("rst_empty", 32'(sb_empty), 32'd1);
        chk("rst_err", 32'(sb_err), 32'd0);

        idle();
        rst_n = 1'b1;
        tick();
        // rs 5 read with nothing outstanding
        rs_id = 5'd5; use_rs = 1'b1; issue_valid = 1'b1;
        #1;
        chk("rel_stall", 32'(stall), 32'd0);
        chk("rel_ack", 32'(issue_ack), 32'd1);

        // ---------------- load-use on r8 ----------------
        issue(5'd8);
        #1;
        chk("lu_issue_ack", 32'(issue_ack), 32'd1);
        tick();
        idle();
        issue_valid = 1'b1; rs_id = 5'd8; use_rs = 1'b1;
        #1;
        chk("lu_stall1", 32'(stall), 32'd1);
        chk("lu_ack1", 32'(issue_ack), 32'd0);
        chk("lu_busy", busy_vec, 32'h100);
        chk("lu_empty", 32'(sb_empty), 32'd0);
        tick();
        chk("lu_stall2", 32'(stall), 32'd1);
        wb_valid = 1'b1; wb_rd = 5'd8;
        #1;
        chk("lu_bypass_stall", 32'(stall), 32'd0);
        chk("lu_bypass_ack", 32'(issue_ack), 32'd1);
        tick();
        idle();
        #1;
        chk("lu_busy_clr", busy_vec, 32'h0);
        chk("lu_empty_clr", 32'(sb_empty), 32'd1);

        // ---------------- two writes in flight to r3 ----------------
        issue(5'd3);
        tick();
        issue(5'd3);
        tick();
        // count 2: a single WB on r3 must not bypass
        wb(5'd3);
        issue_valid = 1'b1; rt_id = 5'd3; use_rt = 1'b1;
        #1;
        chk("mw_cnt2_stall", 32'(stall), 32'd1);
        tick();
        idle();
        issue_valid = 1'b1; rt_id = 5'd3; use_rt = 1'b1;
        #1;
        chk("mw_cnt1_stall", 32'(stall), 32'd1);
        chk("mw_busy", busy_vec, 32'h8);
        wb_valid = 1'b1; wb_rd = 5'd3;
        #1;
        chk("mw_release", 32'(stall), 32'd0);
        tick();
        idle();
        #1;
        chk("mw_busy_clr", busy_vec, 32'h0);

        // ---------------- saturation on r4 ----------------
        for (int i = 0; i < 3; i++) begin
            issue(5'd4);
            #1;
            chk("sat_ack_fill", 32'(issue_ack), 32'd1);
            tick();
        end
        issue(5'd4);
        #1;
        chk("sat_busy", busy_vec, 32'h10);
        chk("sat_stall", 32'(stall), 32'd1);
        chk("sat_ack", 32'(issue_ack), 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd4;
        #1;
        chk("sat_wb_stall", 32'(stall), 32'd0);
        chk("sat_wb_ack", 32'(issue_ack), 32'd1);
        tick();
        // count must still be 3: two WBs leave it busy, the third clears it
        wb(5'd4);
        tick();
        tick();
        chk("sat_drain2", busy_vec, 32'h10);
        tick();
        idle();
        #1;
        chk("sat_drain3", busy_vec, 32'h0);
        chk("sat_no_err", 32'(sb_err), 32'd0);

        // ---------------- register 0 and underflow ----------------
        issue(5'd0);
        #1;
        chk("r0_ack", 32'(issue_ack), 32'd1);
        tick();
        chk("r0_busy", busy_vec, 32'h0);
        chk("r0_empty", 32'(sb_empty), 32'd1);
        wb(5'd0);
        tick();
        idle();
        chk("r0_wb_err", 32'(sb_err), 32'd0);
        wb(5'd9);
        #1;
        chk("uf_err_before", 32'(sb_err), 32'd0);
        tick();
        idle();
        chk("uf_err_set", 32'(sb_err), 32'd1);
        chk("uf_busy", busy_vec, 32'h0);
        flush = 1'b1;
        tick();
        idle();
        chk("uf_err_after_flush", 32'(sb_err), 32'd1);

        // ---------------- flush with pending r2 and r7 ----------------
        issue(5'd2);
        tick();
        issue(5'd7);
        tick();
        idle();
        #1;
        chk("fl_busy", busy_vec, 32'h84);
        issue(5'd2);
        flush = 1'b1;
        #1;
        chk("fl_ack", 32'(issue_ack), 32'd1);
        // stall still reflects the pre-flush counters
        rs_id = 5'd7; use_rs = 1'b1;
        #1;
        chk("fl_stall_old_state", 32'(stall), 32'd1);
        use_rs = 1'b0;
        tick();
        idle();
        chk("fl_busy_clr", busy_vec, 32'h0);
        chk("fl_empty", 32'(sb_empty), 32'd1);

        // ---------------- asynchronous reset between edges ----------------
        issue(5'd7);
        tick();
        idle();
        chk("ar_busy_pre", busy_vec, 32'h80);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_busy", busy_vec, 32'h0);
        chk("ar_empty", 32'(sb_empty), 32'd1);
        chk("ar_err", 32'(sb_err), 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
